// File: rtl/bitrev_sequencer_pkg.sv
// Shared constants and FSM encoding for the bit-reverse permutation sequencer.
// The DEF_* values are the defaults the top-level parameters pick up.
package bitrev_sequencer_pkg;

    localparam int PE_NUMBER     = 32;
    localparam int DATA_SIZE_ARB = 16;
    localparam int DEF_CYCLE_W   = 4;
    localparam int DEF_BEATS     = 1 << DEF_CYCLE_W;
    localparam int DEF_LATENCY   = 2;
    localparam int DEF_CNT_W     = 16;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = S_IDLE,
        ST_STREAM = S_STREAM,
        ST_DRAIN  = S_DRAIN,
        ST_DONE   = S_DONE
    } seq_state_t;

endpackage

// File: rtl/bitrev_valid_pipe.sv
// Fixed-latency shift register carrying {valid, first, last} markers.
// Reusable alongside any stage whose data path has a fixed pipeline depth.
module bitrev_valid_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_valid,
    input  logic i_first,
    input  logic i_last,
    output logic o_valid,
    output logic o_first,
    output logic o_last
);

    logic [DEPTH-1:0][2:0] r_stage;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= {i_valid, i_first, i_last};
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_valid = r_stage[DEPTH-1][2];
    assign o_first = r_stage[DEPTH-1][1];
    assign o_last  = r_stage[DEPTH-1][0];

endmodule

// File: rtl/bitrev_sequencer.sv
// Frame sequencer for the 32-lane bit-reverse permutation: counts input beats,
// drives the permutation cycle index and emits latency-aligned output markers.
module bitrev_sequencer
    import bitrev_sequencer_pkg::*;
#(
    parameter int CYCLE_W = DEF_CYCLE_W,
    parameter int BEATS   = DEF_BEATS,
    parameter int LATENCY = DEF_LATENCY,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    output logic [CYCLE_W-1:0] o_cycle,
    output logic               o_out_valid,
    output logic               o_out_first,
    output logic               o_out_last,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_start_err,
    output logic [CNT_W-1:0]   o_frame_count
);

    seq_state_t         r_state;
    seq_state_t         w_next_state;
    logic [CYCLE_W-1:0] r_beat_cnt;
    logic [CNT_W-1:0]   r_frame_count;
    logic               r_start_err;

    logic w_accept;
    logic w_first_beat;
    logic w_last_beat;
    logic w_pipe_valid;
    logic w_pipe_first;
    logic w_pipe_last;

    assign w_accept     = (r_state == ST_STREAM) && i_in_valid;
    assign w_first_beat = (r_beat_cnt == '0);
    assign w_last_beat  = (r_beat_cnt == CYCLE_W'(BEATS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // DRAIN ends in the cycle the last beat leaves the pipe, so DONE follows
    // immediately after the final permuted beat.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (i_start) w_next_state = ST_STREAM;
            ST_STREAM: if (w_accept && w_last_beat) w_next_state = ST_DRAIN;
            ST_DRAIN:  if (w_pipe_last) w_next_state = ST_DONE;
            ST_DONE:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_beat_cnt <= '0;
        end else if (r_state == ST_IDLE && i_start) begin
            r_beat_cnt <= '0;
        end else if (w_accept) begin
            r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_count <= '0;
            r_start_err   <= 1'b0;
        end else begin
            if (r_state == ST_DONE) begin
                r_frame_count <= r_frame_count + 1'b1;
            end
            if (i_start && r_state != ST_IDLE) begin
                r_start_err <= 1'b1;
            end
        end
    end

    bitrev_valid_pipe #(
        .DEPTH (LATENCY)
    ) u_valid_pipe (
        .clk     (clk),
        .reset   (reset),
        .i_valid (w_accept),
        .i_first (w_accept && w_first_beat),
        .i_last  (w_accept && w_last_beat),
        .o_valid (w_pipe_valid),
        .o_first (w_pipe_first),
        .o_last  (w_pipe_last)
    );

    assign o_in_ready    = (r_state == ST_STREAM);
    assign o_cycle       = r_beat_cnt;
    assign o_out_valid   = w_pipe_valid;
    assign o_out_first   = w_pipe_first;
    assign o_out_last    = w_pipe_last;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_done        = (r_state == ST_DONE);
    assign o_start_err   = r_start_err;
    assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_bitrev_sequencer.sv
// Scoreboard bench for bitrev_sequencer: the driver queues expected output
// beats on acceptance, the monitor checks them when out_valid appears.
module tb_bitrev_sequencer;

    localparam int BEATS   = 16;
    localparam int LATENCY = 2;
    localparam int NONE    = -1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_start = 1'b0;
    logic        i_in_valid = 1'b0;
    logic        o_in_ready;
    logic [3:0]  o_cycle;
    logic        o_out_valid;
    logic        o_out_first;
    logic        o_out_last;
    logic        o_busy;
    logic        o_done;
    logic        o_start_err;
    logic [15:0] o_frame_count;

    typedef struct {
        int cyc;
        bit first;
        bit last;
    } exp_t;

    exp_t        sbQueue[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cycNum = 0;
    int          doneCount = 0;
    logic [15:0] expFrames = '0;

    bitrev_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .i_start       (i_start),
        .i_in_valid    (i_in_valid),
        .o_in_ready    (o_in_ready),
        .o_cycle       (o_cycle),
        .o_out_valid   (o_out_valid),
        .o_out_first   (o_out_first),
        .o_out_last    (o_out_last),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_start_err   (o_start_err),
        .o_frame_count (o_frame_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycNum <= cycNum + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every out_valid beat must match the oldest queued expectation,
    // arriving exactly LATENCY clocks after its acceptance.
    always @(negedge clk) begin
        if (!reset) begin
            if (o_out_valid) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("sb_unexpected_beat", 32'(sbQueue.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = sbQueue.pop_front();
                    checkOutput("out_first", 32'(o_out_first), 32'(e.first));
                    checkOutput("out_last", 32'(o_out_last), 32'(e.last));
                    checkOutput("out_latency", 32'(cycNum - e.cyc), 32'(LATENCY));
                end
            end
            if (o_done) begin
                doneCount++;
                checkOutput("drained_at_done", 32'(sbQueue.size()), 32'd0);
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(o_in_ready), 32'd0);
        checkOutput({tag, "_cycle"}, 32'(o_cycle), 32'd0);
        checkOutput({tag, "_out_valid"}, 32'(o_out_valid), 32'd0);
        checkOutput({tag, "_out_first"}, 32'(o_out_first), 32'd0);
        checkOutput({tag, "_out_last"}, 32'(o_out_last), 32'd0);
        checkOutput({tag, "_busy"}, 32'(o_busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(o_done), 32'd0);
        checkOutput({tag, "_start_err"}, 32'(o_start_err), 32'd0);
        checkOutput({tag, "_frame_count"}, 32'(o_frame_count), 32'd0);
    endtask

    // Call at a negedge while the DUT is IDLE; returns at the negedge after
    // DONE (DUT IDLE again) or after an aborting reset has been released.
    task automatic applyStimulus(input int gapBeatA, input int gapBeatB, input int gapLen,
                                 input int startAtBeat, input int abortAtBeat);
        int beat = 0;
        int gapLeft = 0;
        int guard = 0;
        int donesBefore;
        bit gapADone = 0;
        bit gapBDone = 0;
        bit v;
        donesBefore = doneCount;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        checkOutput("busy_after_start", 32'(o_busy), 32'd1);
        while (beat < BEATS && guard < 200) begin
            guard++;
            if (beat == abortAtBeat) begin
                #2 reset = 1'b1;
                #1;
                i_in_valid = 1'b0;
                checkAllZero("abort");
                sbQueue.delete();
                expFrames = '0;
                @(negedge clk);
                @(negedge clk);
                #2 reset = 1'b0;
                repeat (3) @(negedge clk);
                checkOutput("no_done_after_reset", 32'(doneCount - donesBefore), 32'd0);
                checkOutput("idle_after_reset", 32'(o_busy), 32'd0);
                return;
            end
            if (gapLeft == 0 && beat == gapBeatA && !gapADone) begin
                gapADone = 1;
                gapLeft = gapLen;
            end
            if (gapLeft == 0 && beat == gapBeatB && !gapBDone) begin
                gapBDone = 1;
                gapLeft = gapLen;
            end
            v = (gapLeft == 0);
            if (gapLeft > 0) gapLeft--;
            i_in_valid = v;
            i_start = (beat == startAtBeat) && v;
            checkOutput("in_ready", 32'(o_in_ready), 32'd1);
            checkOutput("cycle", 32'(o_cycle), 32'(beat));
            if (v) begin
                sbQueue.push_back('{cyc: cycNum, first: (beat == 0), last: (beat == BEATS - 1)});
                beat++;
            end
            @(negedge clk);
        end
        i_in_valid = 1'b0;
        i_start = 1'b0;
        checkOutput("in_ready_drain", 32'(o_in_ready), 32'd0);
        guard = 0;
        while (!o_done && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("done_seen", 32'(o_done), 32'd1);
        checkOutput("cycle_after_frame", 32'(o_cycle), 32'd0);
        @(negedge clk);
        expFrames = expFrames + 16'd1;
        checkOutput("frame_count", 32'(o_frame_count), 32'(expFrames));
        checkOutput("busy_idle", 32'(o_busy), 32'd0);
        checkOutput("done_pulses", 32'(doneCount - donesBefore), 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation did not finish in time");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        #3;
        checkAllZero("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkAllZero("post_reset");

        $display("[TB] basic frame, in_valid held high");
        applyStimulus(NONE, NONE, 0, NONE, NONE);

        $display("[TB] gapped frame then back-to-back frames");
        applyStimulus(5, 11, 3, NONE, NONE);
        applyStimulus(NONE, NONE, 0, NONE, NONE);
        checkOutput("start_err_clear", 32'(o_start_err), 32'd0);

        $display("[TB] start during STREAM");
        applyStimulus(NONE, NONE, 0, 4, NONE);
        checkOutput("start_err_set", 32'(o_start_err), 32'd1);
        repeat (5) @(negedge clk);
        checkOutput("no_second_frame", 32'(o_busy), 32'd0);
        checkOutput("start_err_sticky", 32'(o_start_err), 32'd1);

        $display("[TB] reset mid-frame at beat 8");
        applyStimulus(NONE, NONE, 0, NONE, 8);
        checkOutput("start_err_reset", 32'(o_start_err), 32'd0);
        applyStimulus(2, NONE, 1, NONE, NONE);

        $display("[TB] frame_count wrap");
        force dut.r_frame_count = 16'hFFFF;
        @(negedge clk);
        release dut.r_frame_count;
        expFrames = 16'hFFFF;
        applyStimulus(NONE, NONE, 0, NONE, NONE);
        checkOutput("frame_count_wrapped", 32'(o_frame_count), 32'd0);

        repeat (4) @(negedge clk);
        checkOutput("sb_empty_end", 32'(sbQueue.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bitrev_sequencer.md
Name: bitrev_sequencer

Overview:
Control block for the 32-lane bit-reverse permutation stage. It sequences one polynomial frame of BEATS input beats, drives the permutation's 4-bit cycle index, and accepts the upstream valid/ready handshake. It tracks the permutation's fixed 2-cycle pipeline and emits output valid/first/last markers aligned with the permuted data. It sits between the coefficient source (input buffer/PE array) and the permutation stage, and signals frame completion to the top-level NTT controller.

Parameters:
BEATS, 16, beats per frame; must equal 2**CYCLE_W
CYCLE_W, 4, width of cycle index to permutation stage
LATENCY, 2, permutation pipeline depth in clocks (input beat to data_out)
CNT_W, 16, frame counter width

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  pulse; begin a frame (honoured only in IDLE)
in_valid  input  1  upstream beat valid
in_ready  output  1  sequencer accepts beat this cycle
cycle  output  CYCLE_W  beat index driven to permutation stage
out_valid  output  1  permuted data valid at permutation data_out
out_first  output  1  qualifies first output beat of frame
out_last  output  1  qualifies last output beat of frame
busy  output  1  high from start accept until done
done  output  1  one-cycle pulse, frame fully drained
start_err  output  1  sticky; start seen while not IDLE; cleared by reset only
frame_count  output  CNT_W  completed frames, wraps modulo 2**CNT_W

Behaviour:
- Reset is asynchronous, active-high; clock is clk. All outputs and state reset to 0; state=IDLE; in_ready=0.
- FSM states: IDLE, STREAM, DRAIN, DONE.
- IDLE: start=1 -> STREAM next cycle; beat counter cleared to 0; busy=1 from the next cycle.
- STREAM: in_ready=1. A beat is accepted when in_valid & in_ready. The cycle output equals the beat counter, combinationally, so the permutation samples cycle alongside data_in.
- STREAM, beat accepted: the counter increments. When beat BEATS-1 is accepted, the counter wraps to 0 and the state moves to DRAIN. A gap (in_valid=0) holds the counter; there is no timeout.
- Valid pipeline: LATENCY-deep shift register of {accepted, first, last}. first = accepted & counter==0; last = accepted & counter==BEATS-1. out_valid/out_first/out_last are the register outputs, so the stage-N input beat appears exactly LATENCY clocks after acceptance. Gaps propagate as out_valid=0.
- DRAIN: in_ready=0. Stays in DRAIN until the shift register holds no valid beat, i.e. the cycle in which out_last=1 has been emitted. Then -> DONE.
- DONE: done=1 for one cycle, frame_count increments, busy=0 in the next cycle, -> IDLE.
- Throughput: the minimum frame period is BEATS+LATENCY+2 clocks. No overlap of frames.
- The permutation stage has no stall input, so downstream must accept every out_valid beat. There is no out_ready.
- start in STREAM/DRAIN/DONE is ignored and sets start_err. start in the same cycle as the DONE->IDLE transition is ignored; it must arrive in IDLE.
- in_valid while in IDLE/DRAIN/DONE: not accepted, no effect.
- Reset mid-frame: immediate return to IDLE, pipeline valid bits cleared, no done pulse, frame_count cleared.
- frame_count wraps 0xFFFF -> 0 without flag.

Decomposition:
- Shared defines: PE_NUMBER (32), DATA_SIZE_ARB, BEATS/CYCLE_W, LATENCY constants, FSM state encodings (2-bit localparams).
- One sub-module, bitrev_valid_pipe: parameterised LATENCY-deep shift register carrying {valid, first, last} with async reset. Instantiated once; also reusable for other fixed-latency stages.

Test Plan:
- Reset then start, in_valid held 1 -> in_ready high 16 cycles; cycle runs 0..15; out_valid high 16 cycles starting 2 clocks after first accept; out_first with beat 0, out_last with beat 15; done once; frame_count=1.
- in_valid deasserted at beats 5 and 11 for 3 cycles each -> cycle holds at 5/11; out_valid gaps of 3 cycles appear 2 clocks later; 16 valid outputs total; done after last.
- start pulsed during STREAM -> start_err=1 sticky; frame completes normally; no second frame starts.
- Reset asserted at beat 8 -> all outputs 0 immediately (asynchronous); no done; next start produces a full, correct frame starting at cycle=0.
- Back-to-back frames with start issued in IDLE right after done -> frame_count 1,2,3; each frame has exactly one out_first and one out_last.
- Force frame_count to 0xFFFF via 65535 frames (or a bind/force) -> the next done wraps it to 0.
